// File: rtl/my_scaled_muldiv.sv
// my_scaled_muldiv: 3-stage pipelined unsigned (a*b*K[n]) >> SHIFT_W custom instruction, rev 1.0.
// Build option: define MY_MULDIV_SAT_EN to saturate oversized results instead of truncating.
`default_nettype none

module my_scaled_muldiv #(
  parameter int              DATA_W  = 32,
  parameter int              K_W     = 24,
  parameter int              SHIFT_W = 21,
  parameter logic [K_W-1:0]  K0      = K_W'(5243),
  parameter logic [K_W-1:0]  K1      = K_W'(2097152),
  parameter logic [K_W-1:0]  K2      = K_W'(20972),
  parameter logic [K_W-1:0]  K3      = K_W'(2097)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [2:0]        n,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int P_W = 2 * DATA_W;
  localparam int S_W = P_W + K_W;
  localparam int R_W = S_W + 1 - SHIFT_W;

  logic              s1_valid;
  logic [2:0]        s1_n;
  logic [P_W-1:0]    s1_p;
  logic              s2_valid;
  logic              s2_rnd;
  logic [S_W-1:0]    s2_s;

  logic [K_W-1:0]    k_sel;
  logic [S_W:0]      rnd_add;
  logic [S_W:0]      sum;
  logic [R_W-1:0]    r;
  logic [DATA_W-1:0] res_next;

  always_comb begin
    k_sel = K0;
    case (s1_n[1:0])
      2'd0:    k_sel = K0;
      2'd1:    k_sel = K1;
      2'd2:    k_sel = K2;
      default: k_sel = K3;
    endcase
  end

  // One extra bit of headroom makes the half-LSB rounding add unable to wrap.
  always_comb begin
    rnd_add              = '0;
    rnd_add[SHIFT_W-1]   = s2_rnd;
    sum                  = {1'b0, s2_s} + rnd_add;
    r                    = sum[S_W:SHIFT_W];
  end

`ifdef MY_MULDIV_SAT_EN
  assign res_next = (|r[R_W-1:DATA_W]) ? {DATA_W{1'b1}} : r[DATA_W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^r[R_W-1:DATA_W];
  assign res_next  = r[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_n     <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_rnd   <= 1'b0;
      s2_s     <= '0;
      done     <= 1'b0;
      result   <= '0;
    end else if (clk_en) begin
      s1_valid <= start;
      if (start) begin
        s1_p <= {{DATA_W{1'b0}}, dataa} * {{DATA_W{1'b0}}, datab};
        s1_n <= n;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_s   <= {{K_W{1'b0}}, s1_p} * {{P_W{1'b0}}, k_sel};
        s2_rnd <= s1_n[2];
      end
      done <= s2_valid;
      if (s2_valid) begin
        result <= res_next;
      end
    end
  end

endmodule

`default_nettype wire
